// File: rtl/regfile_pkg.sv
// Shared types and constants for the register file and its write-port arbiter.
package regfile_pkg;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;
    localparam int N_REG  = 32;

    // X31 reads as zero; writes to it are swallowed before the write port.
    localparam logic [ADDR_W-1:0] XZR_ADDR = 5'd31;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The grant is combinational from the valids,
// stall, reset and the priority flop; priority flips to the loser after each grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       stall,
    input  logic [1:0] valid,
    output logic [1:0] grant,
    output logic       prio,
    output logic       last_grant
);

    logic prio_q, prio_d;
    logic last_grant_q, last_grant_d;

    // One-hot grant: nothing during reset or stall, otherwise prio breaks ties.
    always_comb begin
        grant = 2'b00;
        if (!reset && !stall) begin
            if (valid == 2'b11) begin
                grant = prio_q ? 2'b10 : 2'b01;
            end else begin
                grant = valid;
            end
        end
    end

    // After a grant the other requester gets priority; with no grant everything holds.
    always_comb begin
        prio_d       = prio_q;
        last_grant_d = last_grant_q;
        if (|grant) begin
            last_grant_d = grant[1];
            prio_d       = ~grant[1];
        end
    end

    // Priority and last-grant state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q       <= 1'b0;
            last_grant_q <= 1'b0;
        end else begin
            prio_q       <= prio_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign prio       = prio_q;
    assign last_grant = last_grant_q;

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write port between the ALU (req0) and load (req1)
// writeback paths. The port is driven from flops so the register file sees
// clean write controls; writes to X31 are accepted but counted and dropped.
module regfile_wr_arbiter #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int DROP_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              w_signal,
    output logic [ADDR_W-1:0] w_addres,
    output logic [DATA_W-1:0] w_input,
    output logic              last_grant,
    output logic [DROP_W-1:0] xzr_drops
);

    import regfile_pkg::*;

    localparam logic [ADDR_W-1:0] ZR = ADDR_W'(XZR_ADDR);

    logic [1:0]        valid;
    logic [1:0]        grant;
    logic              prio_unused;
    logic [ADDR_W-1:0] req_addr [2];
    logic [DATA_W-1:0] req_data [2];
    logic [1:0]        req_xzr;

    logic              xfer;
    logic              sel;
    logic              w_signal_q, w_signal_d;
    logic [ADDR_W-1:0] w_addres_q, w_addres_d;
    logic [DATA_W-1:0] w_input_q,  w_input_d;
    logic [DROP_W-1:0] xzr_drops_q, xzr_drops_d;

    assign valid       = {req1_valid, req0_valid};
    assign req_addr[0] = req0_addr;
    assign req_addr[1] = req1_addr;
    assign req_data[0] = req0_data;
    assign req_data[1] = req1_data;

    // Per-requester flag for writes that target the zero register.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_xzr
            assign req_xzr[gi] = (req_addr[gi] == ZR);
        end
    endgenerate

    rr_arb2 u_arb (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .valid      (valid),
        .grant      (grant),
        .prio       (prio_unused),
        .last_grant (last_grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign xfer       = |grant;
    assign sel        = grant[1];

    // Output stage next state: capture the granted request; enable only for real registers.
    always_comb begin
        w_signal_d  = 1'b0;
        w_addres_d  = w_addres_q;
        w_input_d   = w_input_q;
        xzr_drops_d = xzr_drops_q;
        if (xfer) begin
            w_addres_d = req_addr[sel];
            w_input_d  = req_data[sel];
            w_signal_d = ~req_xzr[sel];
            if (req_xzr[sel] && (xzr_drops_q != {DROP_W{1'b1}})) begin
                xzr_drops_d = xzr_drops_q + DROP_W'(1);
            end
        end
    end

    // Registered write port and drop counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            w_signal_q  <= 1'b0;
            w_addres_q  <= '0;
            w_input_q   <= '0;
            xzr_drops_q <= '0;
        end else begin
            w_signal_q  <= w_signal_d;
            w_addres_q  <= w_addres_d;
            w_input_q   <= w_input_d;
            xzr_drops_q <= xzr_drops_d;
        end
    end

    assign w_signal  = w_signal_q;
    assign w_addres  = w_addres_q;
    assign w_input   = w_input_q;
    assign xzr_drops = xzr_drops_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench: table of hand-derived vectors plus corner sequences,
// with expected port writes queued at acceptance and popped one cycle later.
module tb_regfile_wr_arbiter;

    import regfile_pkg::*;

    logic        clk = 1'b0;
    logic        reset, stall;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [4:0]  req0_addr, req1_addr, w_addres;
    logic [63:0] req0_data, req1_data, w_input;
    logic        w_signal, last_grant;
    logic [7:0]  xzr_drops;

    always #5 clk = ~clk;

    regfile_wr_arbiter #(.DATA_W(64), .ADDR_W(5), .DROP_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .w_signal   (w_signal),
        .w_addres   (w_addres),
        .w_input    (w_input),
        .last_grant (last_grant),
        .xzr_drops  (xzr_drops)
    );

    // Register file beside the arbiter, written from the port; X31 never written here.
    logic [63:0] rf [32];
    always @(posedge clk) begin
        if (w_signal) rf[w_addres] <= w_input;
    end

    typedef struct {
        logic        rst;
        logic        st;
        logic        v0;
        logic [4:0]  a0;
        logic [63:0] d0;
        logic        v1;
        logic [4:0]  a1;
        logic [63:0] d1;
        logic        er0;
        logic        er1;
    } vec_t;

    vec_t    vecs[$];
    wr_req_t exp_q[$];
    int      checks = 0;
    int      passes = 0;
    logic    exp_lg = 1'b0;
    int      exp_drops = 0;
    int      vec_no = 0;

    function automatic vec_t mk(logic rst, logic st, logic v0, logic [4:0] a0, logic [63:0] d0,
                                logic v1, logic [4:0] a1, logic [63:0] d1, logic er0, logic er1);
        vec_t v;
        v.rst = rst; v.st = st;
        v.v0 = v0; v.a0 = a0; v.d0 = d0;
        v.v1 = v1; v.a1 = a1; v.d1 = d1;
        v.er0 = er0; v.er1 = er1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic note_accept(input logic [4:0] a, input logic [63:0] d, input logic g);
        wr_req_t e;
        exp_lg = g;
        if (a == 5'd31) begin
            if (exp_drops < 255) exp_drops++;
        end else begin
            e.addr = a;
            e.data = d;
            exp_q.push_back(e);
        end
    endtask

    // Apply one vector: check readies, queue expectations, clock, check the port.
    task automatic run_vec(input vec_t v);
        wr_req_t e;
        reset = v.rst; stall = v.st;
        req0_valid = v.v0; req0_addr = v.a0; req0_data = v.d0;
        req1_valid = v.v1; req1_addr = v.a1; req1_data = v.d1;
        #1;
        chk("req0_ready", 64'(req0_ready), 64'(v.er0));
        chk("req1_ready", 64'(req1_ready), 64'(v.er1));
        if (v.er0) note_accept(v.a0, v.d0, 1'b0);
        if (v.er1) note_accept(v.a1, v.d1, 1'b1);
        @(posedge clk);
        #1;
        if (v.rst) begin
            exp_q.delete();
            exp_lg = 1'b0;
            exp_drops = 0;
            chk("w_signal_rst", 64'(w_signal), 64'd0);
            chk("w_addres_rst", 64'(w_addres), 64'd0);
            chk("w_input_rst", w_input, 64'd0);
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("w_signal", 64'(w_signal), 64'd1);
            chk("w_addres", 64'(w_addres), 64'(e.addr));
            chk("w_input", w_input, e.data);
        end else begin
            chk("w_signal_idle", 64'(w_signal), 64'd0);
        end
        chk("last_grant", 64'(last_grant), 64'(exp_lg));
        chk("xzr_drops", 64'(xzr_drops), 64'(exp_drops));
        $display("vec %0d rst=%0b st=%0b r0=%0b r1=%0b w=%0b addr=%0d data=%h lg=%0b drops=%0d",
                 vec_no, v.rst, v.st, req0_ready, req1_ready, w_signal, w_addres, w_input,
                 last_grant, xzr_drops);
        vec_no++;
    endtask

    vec_t idle;

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 64'd0;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset, with a request presented that must not be accepted.
        run_vec(mk(1, 0, 1, 5, 64'h1, 0, 0, 0, 0, 0));
        run_vec(mk(1, 0, 1, 5, 64'h1, 0, 0, 0, 0, 0));

        // Reset then idle: all outputs stay zero.
        for (int i = 0; i < 5; i++) begin
            run_vec(idle);
            chk("idle_addr", 64'(w_addres), 64'd0);
            chk("idle_data", w_input, 64'd0);
        end

        // Main table: single requester, alternation, stall, XZR write.
        vecs.push_back(mk(0, 0, 1, 5, 64'hDEAD, 0, 0, 0, 1, 0));
        vecs.push_back(idle);
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 3, 64'h33, 0, 1));
        for (int i = 0; i < 6; i++) begin
            vecs.push_back(mk(0, 0, 1, 1, 64'h100 + 64'((i + 1) / 2), 1, 2, 64'h200 + 64'(i / 2),
                              (i % 2) == 0, (i % 2) == 1));
        end
        vecs.push_back(mk(0, 0, 1, 1, 64'h110, 1, 2, 64'h210, 1, 0));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 1, 1, 1, 64'h111, 1, 2, 64'h210, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 64'h111, 1, 2, 64'h210, 0, 1));
        vecs.push_back(mk(0, 0, 1, 31, 64'h1, 0, 0, 0, 1, 0));
        vecs.push_back(idle);
        foreach (vecs[i]) run_vec(vecs[i]);

        // Same-address conflict with prio=0: req1 lands last, X7 = 2.
        run_vec(mk(0, 0, 0, 0, 0, 1, 4, 64'h44, 0, 1));
        run_vec(mk(0, 0, 1, 7, 64'h1, 1, 7, 64'h2, 1, 0));
        run_vec(mk(0, 0, 0, 0, 0, 1, 7, 64'h2, 0, 1));
        run_vec(idle);
        chk("x7_prio0", rf[7], 64'h2);

        // Same-address conflict with prio=1: req0 lands last, X7 = 1.
        run_vec(mk(0, 0, 1, 8, 64'h88, 0, 0, 0, 1, 0));
        run_vec(mk(0, 0, 1, 7, 64'h1, 1, 7, 64'h2, 0, 1));
        run_vec(mk(0, 0, 1, 7, 64'h1, 0, 0, 0, 1, 0));
        run_vec(idle);
        chk("x7_prio1", rf[7], 64'h1);

        // Reset in a transfer cycle: nothing written, contents unchanged.
        run_vec(mk(1, 0, 1, 9, 64'h99, 1, 10, 64'h1010, 0, 0));
        run_vec(idle);
        run_vec(idle);
        chk("x9_after_rst", rf[9], 64'h0);
        chk("x10_after_rst", rf[10], 64'h0);
        chk("x7_after_rst", rf[7], 64'h1);

        // XZR writes held for 300 cycles: always ready, never written, counter saturates.
        for (int i = 0; i < 300; i++) run_vec(mk(0, 0, 0, 0, 0, 1, 31, 64'h1, 0, 1));
        chk("drops_sat", 64'(xzr_drops), 64'd255);
        run_vec(idle);
        chk("x31", rf[31], 64'h0);

        // Final register contents from the earlier table.
        chk("x5", rf[5], 64'hDEAD);
        chk("x3", rf[3], 64'h33);
        chk("x1", rf[1], 64'h110);
        chk("x2", rf[2], 64'h210);
        chk("x8", rf[8], 64'h88);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
